turn_signal_input: RTL and testbench

Input-conditioning stage directly upstream of the tail-light sequencer FSM. It synchronizes and debounces the raw left/right turn switches and stretches each press into a request that persists until the sequencer's step strobe consumes it. It also generates that step strobe (`tick`), so the sequencer advances at a visible rate. Outputs are one-hot, with left having priority, matching the sequencer's priority.

---
 rtl/tbird_pkg.sv | 23 ++
 rtl/switch_debouncer.sv | 60 ++++++
 rtl/turn_signal_input.sv | 108 ++++++++++
 tb/tb_turn_signal_input.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
// Shared definitions for the tail-light datapath: default timing constants
// for the input conditioning stage and the lamp patterns the sequencer drives.
// No ports; imported by turn_signal_input and switch_debouncer.
package tbird_pkg;

  // ~5 ms debounce and ~4 steps/s tick at a 50 MHz system clock.
  localparam int TBIRD_DEBOUNCE_CYCLES = 250000;
  localparam int TBIRD_TICK_DIV        = 12500000;

  // Per-side lamp group, bit 0 is the innermost lamp (A), bit 2 the outermost (C).
  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMPS_OFF = 3'b000;
  localparam lamp_t LAMP_A    = 3'b001;
  localparam lamp_t LAMP_AB   = 3'b011;
  localparam lamp_t LAMP_ABC  = 3'b111;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Conditions one raw, bouncy, asynchronous switch.
//   clk, reset : system clock, asynchronous active-high reset
//   sw_i       : raw switch input
//   stable_o   : debounced switch level
//   press_o    : one-cycle pulse on the cycle after stable_o rises
// A change is accepted only after the synchronized level has differed from
// the stable level for DEBOUNCE_CYCLES consecutive cycles.
module switch_debouncer
  import tbird_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TBIRD_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_i,
  output logic stable_o,
  output logic press_o
);

  localparam int               CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Debounce decision; any single agreeing cycle restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sw_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = stable_q & ~stable_dly_q;

endmodule

// File: rtl/turn_signal_input.sv
// Input conditioning for the tail-light sequencer.
//   clk, reset          : system clock, asynchronous active-high reset
//   sw_left, sw_right   : raw turn switches (asynchronous, bouncy)
//   left, right         : registered one-hot requests, left has priority
//   tick                : registered one-cycle step strobe every TICK_DIV cycles
// Each debounced press is latched until a tick consumes it while presented;
// a switch still held at that tick keeps requesting. A masked right request
// survives and is presented once left stops requesting.
module turn_signal_input
  import tbird_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = TBIRD_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = TBIRD_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_left,
  input  logic sw_right,
  output logic left,
  output logic right,
  output logic tick
);

  localparam int            TW       = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic          stable_l, stable_r;
  logic          press_l, press_r;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick_q, tick_d;
  logic          pend_l_q, pend_l_d;
  logic          pend_r_q, pend_r_d;
  logic          left_q, left_d;
  logic          right_q, right_d;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_left (
    .clk     (clk),
    .reset   (reset),
    .sw_i    (sw_left),
    .stable_o(stable_l),
    .press_o (press_l)
  );

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_right (
    .clk     (clk),
    .reset   (reset),
    .sw_i    (sw_right),
    .stable_o(stable_r),
    .press_o (press_r)
  );

  always_comb begin
    // Free-running step counter; tick is registered so it lines up with the
    // cycle in which the counter holds TICK_DIV-1.
    tick_cnt_d = (tick_cnt_q == TICK_MAX) ? '0 : tick_cnt_q + 1'b1;
    tick_d     = (tick_cnt_d == TICK_MAX);

    // A press always wins, so a press landing on a tick cycle is kept for the
    // next tick. Clearing needs the request to have actually been on the
    // output during the tick, which is what keeps a masked right alive.
    pend_l_d = pend_l_q;
    if (press_l) begin
      pend_l_d = 1'b1;
    end else if (tick_q && left_q && !stable_l) begin
      pend_l_d = 1'b0;
    end

    pend_r_d = pend_r_q;
    if (press_r) begin
      pend_r_d = 1'b1;
    end else if (tick_q && right_q && !stable_r) begin
      pend_r_d = 1'b0;
    end

    // Next-state latches feed the outputs so a consumed request drops on the
    // edge right after its tick.
    left_d  = pend_l_d | stable_l;
    right_d = (pend_r_d | stable_r) & ~left_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      pend_l_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      pend_l_q   <= pend_l_d;
      pend_r_q   <= pend_r_d;
      left_q     <= left_d;
      right_q    <= right_d;
    end
  end

  assign left  = left_q;
  assign right = right_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_turn_signal_input.sv
module tb_turn_signal_input;

  localparam int DB = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw_left = 1'b1;
  logic sw_right = 1'b1;
  logic left, right, tick;

  int pass_cnt = 0;
  int total_cnt = 0;

  turn_signal_input #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV(TD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_left (sw_left),
    .sw_right(sw_right),
    .left    (left),
    .right   (right),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  // ---------------- behavioural model ----------------
  // Switch level seen by the debouncer is the raw level two edges old.
  // The debounced level flips once the last DB observed samples all disagree
  // with it. A rising debounced level raises a request; the request is
  // withdrawn at a tick where it was on the output and the switch is
  // debounced low. Left wins; outputs show what the requests will be after
  // the edge, combined with the debounced level before it.
  int k = 0;
  bit m_raw1[2], m_s[2], m_st[2], m_stprev[2], m_pend[2];
  bit m_left, m_right, m_tick;
  bit win0[$], win1[$];

  function automatic bit all_differ(input bit q[$], input bit st);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == st) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    bit nst[2];
    bit npend[2];
    bit shown;
    bit nl;
    if (reset) begin
      k = 0;
      for (int c = 0; c < 2; c++) begin
        m_raw1[c] = 0; m_s[c] = 0; m_st[c] = 0; m_stprev[c] = 0; m_pend[c] = 0;
      end
      m_left = 0; m_right = 0; m_tick = 0;
      win0.delete(); win1.delete();
    end else begin
      win0.push_back(m_s[0]); if (win0.size() > DB) void'(win0.pop_front());
      win1.push_back(m_s[1]); if (win1.size() > DB) void'(win1.pop_front());
      nst[0] = all_differ(win0, m_st[0]) ? !m_st[0] : m_st[0];
      nst[1] = all_differ(win1, m_st[1]) ? !m_st[1] : m_st[1];
      for (int c = 0; c < 2; c++) begin
        shown = (c == 0) ? m_left : m_right;
        if (m_st[c] && !m_stprev[c]) npend[c] = 1;
        else if (m_tick && shown && !m_st[c]) npend[c] = 0;
        else npend[c] = m_pend[c];
      end
      nl = npend[0] | m_st[0];
      m_right = (npend[1] | m_st[1]) & !nl;
      m_left = nl;
      k++;
      m_tick = ((k % TD) == TD - 1);
      for (int c = 0; c < 2; c++) begin
        m_stprev[c] = m_st[c];
        m_st[c] = nst[c];
        m_pend[c] = npend[c];
        m_s[c] = m_raw1[c];
      end
      m_raw1[0] = sw_left;
      m_raw1[1] = sw_right;
    end
    #1;
    chk("model_left", int'(left), int'(m_left));
    chk("model_right", int'(right), int'(m_right));
    chk("model_tick", int'(tick), int'(m_tick));
    chk("onehot", int'(left & right), 0);
  end

  // ---------------- directed + random stimulus ----------------
  bit seen_l, seen_r, low_r;

  task automatic cycw(input int n);
    repeat (n) begin
      @(negedge clk);
      seen_l |= left;
      seen_r |= right;
      low_r |= !right;
    end
  endtask

  task automatic wait_fall(input bit is_left, output bit prev_tick, output bit fell);
    fell = 0;
    prev_tick = 0;
    for (int i = 0; i < 40; i++) begin
      prev_tick = tick;
      @(negedge clk);
      if ((is_left ? left : right) == 1'b0) begin
        fell = 1;
        break;
      end
    end
  endtask

  initial begin
    bit pt, fl;
    int rl_l, rl_r;

    // reset held with switches high
    repeat (3) begin
      @(negedge clk);
      chk("reset_left", int'(left), 0);
      chk("reset_right", int'(right), 0);
      chk("reset_tick", int'(tick), 0);
    end
    reset = 0; sw_left = 0; sw_right = 0;

    // tick phase: first after post-reset edge 7, then every 8
    cycw(6);  chk("tick_e6", int'(tick), 0);
    cycw(1);  chk("tick_e7", int'(tick), 1);
    cycw(1);  chk("tick_e8", int'(tick), 0);
    cycw(7);  chk("tick_e15", int'(tick), 1);

    // bounce rejection
    seen_l = 0;
    sw_left = 1; cycw(3); sw_left = 0; cycw(1);
    sw_left = 1; cycw(2); sw_left = 0; cycw(1);
    sw_left = 1; cycw(3); sw_left = 0; cycw(10);
    chk("bounce_reject", int'(seen_l), 0);

    // clean 6-cycle press, latency 7 edges
    sw_left = 1; cycw(6);
    chk("press_lat_e6", int'(left), 0);
    sw_left = 0; cycw(1);
    chk("press_lat_e7", int'(left), 1);
    wait_fall(1, pt, fl);
    chk("stretch_fell", int'(fl), 1);
    chk("stretch_on_tick", int'(pt), 1);
    seen_l = 0; cycw(20);
    chk("stretch_stays_low", int'(seen_l), 0);

    // held right switch
    sw_right = 1; cycw(7);
    chk("held_right_on", int'(right), 1);
    low_r = 0; cycw(33);
    sw_right = 0; cycw(6);
    chk("held_right_continuous", int'(low_r), 0);
    wait_fall(0, pt, fl);
    chk("held_fell", int'(fl), 1);
    chk("held_fall_on_tick", int'(pt), 1);
    cycw(10);

    // simultaneous press
    sw_left = 1; sw_right = 1; cycw(6);
    sw_left = 0; sw_right = 0; cycw(1);
    chk("simul_left", int'(left), 1);
    chk("simul_right_masked", int'(right), 0);
    wait_fall(1, pt, fl);
    chk("simul_left_fell", int'(fl), 1);
    chk("simul_left_on_tick", int'(pt), 1);
    chk("simul_right_shown", int'(right), 1);
    wait_fall(0, pt, fl);
    chk("simul_right_fell", int'(fl), 1);
    chk("simul_right_on_tick", int'(pt), 1);
    cycw(10);

    // reset mid-operation
    sw_right = 1; cycw(6);
    sw_right = 0; cycw(3);
    chk("midrst_pre_right", int'(right), 1);
    reset = 1; #1;
    chk("midrst_right_async", int'(right), 0);
    chk("midrst_tick_async", int'(tick), 0);
    cycw(2);
    reset = 0;
    seen_l = 0; seen_r = 0; cycw(30);
    chk("midrst_no_req", int'(seen_l | seen_r), 0);

    // randomized switch activity
    rl_l = 0; rl_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rl_l == 0) begin sw_left = ~sw_left; rl_l = $urandom_range(1, 12); end
      if (rl_r == 0) begin sw_right = ~sw_right; rl_r = $urandom_range(1, 12); end
      rl_l--; rl_r--;
      if (i == 1500) reset = 1;
      if (i == 1502) reset = 0;
      @(negedge clk);
    end
    sw_left = 0; sw_right = 0;
    cycw(40);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
